// File: rtl/rns_mod_adder_pipe.sv
// Pipelined modular adder/subtractor for one RNS residue channel.
// Two register stages (S1 sum/difference, S2 modular correction) with valid/ready flow control.
module rns_mod_adder_pipe #(
  parameter int unsigned     WIDTH   = 32'd4,
  parameter longint unsigned MODULUS = 64'd16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_err
);

  if ((WIDTH < 32'd2) || (WIDTH > 32'd32)) begin : g_bad_width
    $fatal(1, "rns_mod_adder_pipe: WIDTH must be in 2..32");
  end
  if ((MODULUS < 64'd2) || (MODULUS > (64'd1 << WIDTH))) begin : g_bad_modulus
    $fatal(1, "rns_mod_adder_pipe: MODULUS must be in 2..2^WIDTH");
  end

  localparam logic [WIDTH:0] M = MODULUS[WIDTH:0];

  logic [WIDTH:0]   w_a_x;
  logic [WIDTH:0]   w_b_x;
  logic [WIDTH:0]   w_s;
  logic [WIDTH-1:0] w_sm;
  logic             w_err;
  logic [WIDTH-1:0] w_res;
  logic             w_s1_adv;
  logic             w_s2_adv;

  logic             r_v1;
  logic [WIDTH:0]   r_s;
  logic [WIDTH-1:0] r_sm;
  logic             r_err1;
  logic             r_v2;
  logic [WIDTH-1:0] r_result;
  logic             r_err2;

  // Stage advance conditions; a full stage moves only if its successor frees up.
  always_comb begin
    w_s2_adv = !r_v2 || out_ready;
    w_s1_adv = !r_v1 || w_s2_adv;
  end

  // S1 arithmetic at WIDTH+1 bits so no carry is lost.
  always_comb begin
    w_a_x = {1'b0, a};
    w_b_x = {1'b0, b};
    if (op) begin
      w_s = w_a_x + (M - w_b_x);
    end else begin
      w_s = w_a_x + w_b_x;
    end
    // s - M is only selected when s >= M, so its value always fits in WIDTH bits.
    w_sm  = w_s[WIDTH-1:0] - M[WIDTH-1:0];
    w_err = (w_a_x >= M) || (w_b_x >= M);
  end

  // S2 correction: choose s or s - M; out-of-range operands force zero.
  always_comb begin
    if (r_err1) begin
      w_res = {WIDTH{1'b0}};
    end else if (r_s >= M) begin
      w_res = r_sm;
    end else begin
      w_res = r_s[WIDTH-1:0];
    end
  end

  // S1 register: captures the operand pair on an input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_s    <= {(WIDTH+1){1'b0}};
      r_sm   <= {WIDTH{1'b0}};
      r_err1 <= 1'b0;
    end else if (w_s1_adv) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_s    <= w_s;
        r_sm   <= w_sm;
        r_err1 <= w_err;
      end else begin
        r_s    <= r_s;
        r_sm   <= r_sm;
        r_err1 <= r_err1;
      end
    end else begin
      r_v1   <= r_v1;
      r_s    <= r_s;
      r_sm   <= r_sm;
      r_err1 <= r_err1;
    end
  end

  // S2 register: holds the presented result stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2     <= 1'b0;
      r_result <= {WIDTH{1'b0}};
      r_err2   <= 1'b0;
    end else if (w_s2_adv) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_result <= w_res;
        r_err2   <= r_err1;
      end else begin
        r_result <= r_result;
        r_err2   <= r_err2;
      end
    end else begin
      r_v2     <= r_v2;
      r_result <= r_result;
      r_err2   <= r_err2;
    end
  end

  assign in_ready  = w_s1_adv;
  assign out_valid = r_v2;
  assign result    = r_result;
  assign out_err   = r_err2;

endmodule

// File: tb/tb_rns_mod_adder_pipe.sv
// Self-checking bench for rns_mod_adder_pipe: three channel configurations
// (W4/M16, W3/M7, W32/M=2^32-5) driven from a vector table plus directed sequences.
module tb_rns_mod_adder_pipe;

  logic        clk;
  logic        rst_n;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [2:0]  op_v;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [2:0]  err_v;
  logic [31:0] a_v [3];
  logic [31:0] b_v [3];
  logic [31:0] res_v [3];
  logic [3:0]  res0;
  logic [2:0]  res1;
  logic [31:0] res2;

  int n_chk;
  int n_fail;

  assign res_v[0] = {28'd0, res0};
  assign res_v[1] = {29'd0, res1};
  assign res_v[2] = res2;

  rns_mod_adder_pipe #(.WIDTH(32'd4), .MODULUS(64'd16)) u_m16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_v[0][3:0]), .b(b_v[0][3:0]), .op(op_v[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .result(res0), .out_err(err_v[0]));

  rns_mod_adder_pipe #(.WIDTH(32'd3), .MODULUS(64'd7)) u_m7 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_v[1][2:0]), .b(b_v[1][2:0]), .op(op_v[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .result(res1), .out_err(err_v[1]));

  rns_mod_adder_pipe #(.WIDTH(32'd32), .MODULUS(64'd4294967291)) u_m32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a_v[2]), .b(b_v[2]), .op(op_v[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .result(res2), .out_err(err_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          d;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d (0x%0h), required %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // One isolated transaction: checks acceptance, the 2-cycle latency and the value.
  task automatic apply_one(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    a_v[v.d] = v.a; b_v[v.d] = v.b; op_v[v.d] = v.op;
    in_valid[v.d] = 1'b1; out_ready[v.d] = 1'b1;
    #1;
    chk({tag, " in_ready"}, {31'd0, in_ready[v.d]}, 32'd1);
    @(negedge clk);
    in_valid[v.d] = 1'b0;
    chk({tag, " early_valid"}, {31'd0, out_valid[v.d]}, 32'd0);
    @(negedge clk);
    chk({tag, " out_valid"}, {31'd0, out_valid[v.d]}, 32'd1);
    chk({tag, " result"}, res_v[v.d], v.exp);
    chk({tag, " out_err"}, {31'd0, err_v[v.d]}, {31'd0, v.err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  bp_a [10];
    logic [3:0]  bp_b [10];
    logic        bp_op [10];
    logic [31:0] q [$];
    logic [31:0] prev_res;
    logic        prev_err;
    logic        prev_stall;
    logic        exp_rdy;
    logic        in_x;
    logic        out_x;
    int          sent;
    int          rcvd;
    int          occ;
    int          n_low;
    logic [31:0] ea;
    logic [31:0] eb;

    n_chk = 0; n_fail = 0;
    tbl[0]  = '{1, 32'd6, 32'd6, 1'b0, 32'd5, 1'b0};
    tbl[1]  = '{1, 32'd3, 32'd4, 1'b0, 32'd0, 1'b0};
    tbl[2]  = '{1, 32'd2, 32'd5, 1'b1, 32'd4, 1'b0};
    tbl[3]  = '{1, 32'd5, 32'd0, 1'b1, 32'd5, 1'b0};
    tbl[4]  = '{1, 32'd7, 32'd1, 1'b0, 32'd0, 1'b1};
    tbl[5]  = '{1, 32'd1, 32'd1, 1'b0, 32'd2, 1'b0};
    tbl[6]  = '{1, 32'd0, 32'd6, 1'b1, 32'd1, 1'b0};
    tbl[7]  = '{2, 32'hFFFF_FFFA, 32'hFFFF_FFFA, 1'b0, 32'hFFFF_FFF9, 1'b0};
    tbl[8]  = '{2, 32'd0, 32'd1, 1'b1, 32'hFFFF_FFFA, 1'b0};
    tbl[9]  = '{2, 32'd1, 32'hFFFF_FFFB, 1'b1, 32'd0, 1'b1};
    tbl[10] = '{0, 32'd15, 32'd15, 1'b0, 32'd14, 1'b0};
    tbl[11] = '{0, 32'd3, 32'd5, 1'b1, 32'd14, 1'b0};
    tbl[12] = '{0, 32'd7, 32'd0, 1'b1, 32'd7, 1'b0};
    tbl[13] = '{0, 32'd8, 32'd8, 1'b0, 32'd0, 1'b0};

    rst_n = 1'b0; in_valid = 3'b000; out_ready = 3'b000; op_v = 3'b000;
    for (int i = 0; i < 3; i++) begin
      a_v[i] = 32'd0; b_v[i] = 32'd0;
    end
    repeat (3) @(negedge clk);
    chk("rst out_valid", {29'd0, out_valid}, 32'd0);
    chk("rst result", res_v[0], 32'd0);
    chk("rst out_err", {29'd0, err_v}, 32'd0);
    chk("rst in_ready", {29'd0, in_ready}, 32'd7);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) apply_one(i, tbl[i]);

    // Exhaustive legacy stream: back-to-back adds, result expected exactly 2 cycles later.
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("legacy idle", {31'd0, out_valid[0]}, 32'd0);
    for (int i = 0; i < 258; i++) begin
      if (i > 0) @(negedge clk);
      if (i >= 2) begin
        ea = 32'(((i - 2) >> 4) & 15);
        eb = 32'((i - 2) & 15);
        chk($sformatf("legacy valid %0d", i - 2), {31'd0, out_valid[0]}, 32'd1);
        chk($sformatf("legacy sum %0d+%0d", ea, eb), res_v[0], (ea + eb) & 32'd15);
        chk("legacy err", {31'd0, err_v[0]}, 32'd0);
      end
      if (i < 256) begin
        a_v[0] = 32'((i >> 4) & 15); b_v[0] = 32'(i & 15); op_v[0] = 1'b0;
        in_valid[0] = 1'b1;
        #1;
        chk("legacy in_ready", {31'd0, in_ready[0]}, 32'd1);
      end else begin
        in_valid[0] = 1'b0;
      end
    end
    @(negedge clk);
    chk("legacy drained", {31'd0, out_valid[0]}, 32'd0);

    // Backpressure: 3-low/1-high out_ready while streaming 10 random pairs.
    for (int i = 0; i < 10; i++) begin
      bp_a[i] = 4'($urandom_range(15)); bp_b[i] = 4'($urandom_range(15));
      bp_op[i] = 1'($urandom_range(1));
    end
    sent = 0; rcvd = 0; occ = 0; n_low = 0; prev_stall = 1'b0;
    prev_res = 32'd0; prev_err = 1'b0;
    for (int cyc = 0; cyc < 200 && rcvd < 10; cyc++) begin
      @(negedge clk);
      out_ready[0] = ((cyc % 4) == 3);
      in_valid[0] = (sent < 10);
      if (sent < 10) begin
        a_v[0] = {28'd0, bp_a[sent]}; b_v[0] = {28'd0, bp_b[sent]}; op_v[0] = bp_op[sent];
      end else begin
        a_v[0] = 32'd0; b_v[0] = 32'd0; op_v[0] = 1'b0;
      end
      #1;
      exp_rdy = !((occ == 2) && !out_ready[0]);
      chk("bp in_ready", {31'd0, in_ready[0]}, {31'd0, exp_rdy});
      if (!in_ready[0]) n_low++;
      if (prev_stall) begin
        chk("bp stall valid", {31'd0, out_valid[0]}, 32'd1);
        chk("bp stall result", res_v[0], prev_res);
        chk("bp stall err", {31'd0, err_v[0]}, {31'd0, prev_err});
      end
      out_x = out_valid[0] && out_ready[0];
      if (out_x) begin
        if (q.size() == 0) begin
          chk("bp spurious output", 32'd1, 32'd0);
        end else begin
          chk($sformatf("bp result %0d", rcvd), res_v[0], q.pop_front());
          chk("bp err", {31'd0, err_v[0]}, 32'd0);
        end
        rcvd++;
      end
      in_x = in_valid[0] && in_ready[0];
      if (in_x) begin
        if (bp_op[sent]) q.push_back(({28'd0, bp_a[sent]} + 32'd16 - {28'd0, bp_b[sent]}) & 32'd15);
        else q.push_back(({28'd0, bp_a[sent]} + {28'd0, bp_b[sent]}) & 32'd15);
        sent++;
      end
      occ = occ + (in_x ? 1 : 0) - (out_x ? 1 : 0);
      prev_stall = out_valid[0] && !out_ready[0];
      prev_res = res_v[0];
      prev_err = err_v[0];
    end
    chk("bp all received", 32'(rcvd), 32'd10);
    chk("bp backpressure seen", {31'd0, (n_low > 0)}, 32'd1);
    @(negedge clk);
    in_valid[0] = 1'b0; out_ready[0] = 1'b1;
    repeat (3) @(negedge clk);

    // Reset while a result is stalled at the output.
    out_ready[0] = 1'b0;
    a_v[0] = 32'd9; b_v[0] = 32'd9; op_v[0] = 1'b0; in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("mrst pending valid", {31'd0, out_valid[0]}, 32'd1);
    chk("mrst pending result", res_v[0], 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst out_valid", {31'd0, out_valid[0]}, 32'd0);
    chk("mrst result", res_v[0], 32'd0);
    chk("mrst in_ready", {31'd0, in_ready[0]}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1; out_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post-rst no output", {31'd0, out_valid[0]}, 32'd0);
      chk("post-rst in_ready", {31'd0, in_ready[0]}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rns_mod_adder_pipe.md
Name: rns_mod_adder_pipe

Overview:
- Parametrised, pipelined modular adder/subtractor for one residue channel of the RNS datapath.
- Computes (a op b) mod MODULUS for any modulus up to 2^WIDTH, with valid/ready flow control and an out-of-range operand flag.
- Successor to the fixed 4-bit mod-16 combinational adder: one instance per RNS channel, between the forward converter and the channel multipliers.

Parameters:
- WIDTH, 4, residue bit width; legal range 2..32.
- MODULUS, 16, channel modulus; legal range 2 <= MODULUS <= 2^WIDTH. Illegal values are a fatal elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair a/b/op is presented
- in_ready  output  1  block accepts the operand pair this cycle
- a  input  WIDTH  residue operand A
- b  input  WIDTH  residue operand B
- op  input  1  0 = add, 1 = subtract (a - b)
- out_valid  output  1  result is presented
- out_ready  input  1  downstream accepts the result
- result  output  WIDTH  (a op b) mod MODULUS
- out_err  output  1  a or b was >= MODULUS for this result

Behaviour:
- Reset: rst_n low asserts reset immediately, regardless of clk. Both stage valid bits clear; all data registers clear.
  - Outputs during and after reset: out_valid=0, result=0, out_err=0, in_ready=1.
  - Reset asserted mid-operation discards all in-flight results; nothing is emitted after release.
  - Release is synchronised externally; no handshake completes while rst_n=0.
- Transfers: an input transfer occurs when in_valid and in_ready are both high at a clk edge. An output transfer occurs when out_valid and out_ready are both high.
- Pipeline: two register stages, S1 and S2; latency 2 cycles from input transfer to out_valid with no stalls; throughput 1 per cycle.
- S1 captures the following, all at WIDTH+1 bits:
  - add: s = a + b
  - sub: s = a + (MODULUS - b)
  - also s_m = s - MODULUS
  - err = (a >= MODULUS) | (b >= MODULUS)
- S2 captures the final result:
  - result = s_m if s >= MODULUS, else s; truncated to WIDTH bits.
  - If err=1: result = 0 and out_err = 1.
- Arithmetic: all intermediates are WIDTH+1 bits so that no carry is lost. With MODULUS = 2^WIDTH, the result equals the plain WIDTH-bit wrap (the legacy behaviour). For legal operands, sub with b=0 gives s = a + MODULUS, which corrects to a.
- Flow control:
  - S2 advances when S2 is empty or out_ready=1.
  - S1 advances when S1 is empty or S2 advances.
  - in_ready = S1 empty or S2 advancing (combinational on out_ready; no combinational path from in_valid).
  - When stalled (out_valid=1, out_ready=0), result and out_err hold stable and out_valid stays high.
  - With both stages full and stalled, in_ready=0; a, b and op are ignored.
  - Simultaneous input and output transfer with both stages full: S2 takes S1, and S1 takes the new input; no bubble, no loss.
- Ordering: results leave strictly in input order; no reordering, no drop, no duplication.
- Wrap-around: sums equal to exactly MODULUS produce 0. The maximum legal case (M-1)+(M-1) produces M-2.
- Idle: with in_valid=0, the stages drain in order and out_valid deasserts once both are empty and the last result has transferred.

Test Plan:
- Reset mid-stream: WIDTH=4, MODULUS=16; send a=9,b=9 then assert rst_n=0 before the result is taken -> out_valid drops immediately; after release no result emerges and in_ready=1.
- Legacy equivalence: WIDTH=4, MODULUS=16; exhaustive 256 add pairs with out_ready=1 -> result=(a+b)&15, out_err=0, out_valid exactly 2 cycles after each input transfer.
- Non-power-of-two modulus: WIDTH=3, MODULUS=7:
  - add a=6,b=6 -> 5
  - add a=3,b=4 -> 0
  - sub a=2,b=5 -> 4
  - sub a=5,b=0 -> 5
- Out-of-range operand: MODULUS=7; add a=7,b=1 -> result=0, out_err=1; the next legal pair a=1,b=1 -> result=2, out_err=0.
- Backpressure: stream 10 random pairs back-to-back while toggling out_ready with a 3-cycle-low/1-cycle-high pattern -> in_ready drops only when both stages are full; result and out_err stay stable while stalled; all 10 results arrive in order and are correct.
- Max width: WIDTH=32, MODULUS=2^32-5; add (M-1)+(M-1) -> M-2; sub 0-1 -> M-1.
